// File: rtl/imm_extend_pipe.sv
// Buffered immediate extension (zero/sign/upper/branch) behind a small FIFO.
// Optional perf counters are built when IMM_EXTEND_PERF_EN is defined.

// Generic storage FIFO: DEPTH entries of W bits, pointer based.
// Latency: a write is visible at rdat one cycle after the accepting edge.
// Backpressure: writes are refused while full; reads of an empty FIFO are ignored.
module imm_extend_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               wdat,
   output logic [W-1:0]               rdat,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= wdat;
   end

   assign rdat = empty ? '0 : mem[rd_ptr];
endmodule

// Extends IN_W-bit immediates to OUT_W bits and queues them for the ALU operand mux.
// Latency: one cycle from accepted push to out_valid/dataOut; no comb in->out path.
// Backpressure: in_ready = !full, so a full FIFO refuses a push even when popping.
module imm_extend_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       enable,
   input  logic [1:0]                 mode,
   input  logic [IN_W-1:0]            dataIn,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [OUT_W-1:0]           dataOut,
   output logic [$clog2(DEPTH+1)-1:0] count
`ifdef IMM_EXTEND_PERF_EN
   ,
   output logic [15:0]                perf_push,
   output logic [15:0]                perf_stall
`endif
);
   localparam int PAD = OUT_W - IN_W;

   logic [OUT_W-1:0] zext_dat;
   logic [OUT_W-1:0] sext_dat;
   logic [OUT_W-1:0] upper_dat;
   logic [OUT_W-1:0] branch_dat;
   logic [OUT_W-1:0] ext_dat;
   logic             push;
   logic             pop;
   logic             full;
   logic             empty;

   assign zext_dat   = {{PAD{1'b0}}, dataIn};
   assign sext_dat   = {{PAD{dataIn[IN_W-1]}}, dataIn};
   assign upper_dat  = {dataIn, {PAD{1'b0}}};
   assign branch_dat = {sext_dat[OUT_W-3:0], 2'b00};

   always_comb begin
      ext_dat = '0;
      if (enable) begin
         case (mode)
            2'b00:   ext_dat = zext_dat;
            2'b01:   ext_dat = sext_dat;
            2'b10:   ext_dat = upper_dat;
            default: ext_dat = branch_dat;
         endcase
      end
   end

   assign in_ready  = ~full;
   assign out_valid = ~empty;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   imm_extend_fifo #(
      .W     (OUT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdat  (ext_dat),
      .rdat  (dataOut),
      .full  (full),
      .empty (empty),
      .count (count)
   );

`ifdef IMM_EXTEND_PERF_EN
   // Both counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_push  <= '0;
         perf_stall <= '0;
      end else begin
         if (push && perf_push != 16'hFFFF)
            perf_push <= perf_push + 16'd1;
         if (in_valid && !in_ready && perf_stall != 16'hFFFF)
            perf_stall <= perf_stall + 16'd1;
      end
   end
`endif
endmodule
